// File: rtl/scroll_pkg.sv
// scroll_pkg: shared constants for the background scroll scheduler.
// State encoding, default geometry/speed values and datapath widths.
package scroll_pkg;

  localparam int POS_W = 20;
  localparam int SPD_W = 16;
  localparam int PIX_W = 10;

  localparam int SCREEN_W        = 640;
  localparam int SCALE           = 100;
  localparam int MIN_SPEED       = 100;
  localparam int SPEED_PER_SCORE = 30;
  localparam int MAX_SPEED       = 3000;
  localparam int RAMP_STEP       = 50;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

endpackage

// File: rtl/scroll_scheduler_if.sv
// scroll_scheduler_if: game-side controls in, renderer-side
// background position/skip outputs back.
interface scroll_scheduler_if;
  logic       frameTick;
  logic       start;
  logic       pause;
  logic       gameOver;
  logic [9:0] score;
  logic [9:0] BACK1X;
  logic [9:0] BACK1Y;
  logic [9:0] BACK2X;
  logic [9:0] BACK2Y;
  logic [9:0] BACK1SKIPX;
  logic [9:0] BACK2SKIPX;
  logic       wrapPulse;
  logic [1:0] state;

  modport master (
    output frameTick, start, pause,
    output gameOver, score,
    input  BACK1X, BACK1Y, BACK2X,
    input  BACK2Y, BACK1SKIPX,
    input  BACK2SKIPX, wrapPulse, state
  );

  modport slave (
    input  frameTick, start, pause,
    input  gameOver, score,
    output BACK1X, BACK1Y, BACK2X,
    output BACK2Y, BACK1SKIPX,
    output BACK2SKIPX, wrapPulse, state
  );
endinterface

// File: rtl/scroll_pixel_div.sv
// scroll_pixel_div: registered sub-pixel to pixel conversion.
// Produces the layer-1 x position and layer-2 skip, 1-cycle latency.
module scroll_pixel_div
  import scroll_pkg::*;
#(
  parameter int SCREEN_W_P = SCREEN_W,
  parameter int SCALE_P    = SCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos,
  output logic [PIX_W-1:0] x,
  output logic [PIX_W-1:0] skip
);

  logic [POS_W-1:0] q;
  logic [PIX_W-1:0] x_d;

  assign q = pos / POS_W'(SCALE_P);

  // clamp keeps the renderer in range even for odd pos values
  assign x_d = (q > POS_W'(SCREEN_W_P)) ?
               PIX_W'(SCREEN_W_P) : q[PIX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= PIX_W'(SCREEN_W_P);
      skip <= '0;
    end else begin
      x    <= x_d;
      skip <= PIX_W'(SCREEN_W_P) - x_d;
    end
  end

endmodule

// File: rtl/scroll_scheduler.sv
// scroll_scheduler: run-state FSM, speed ramp and sub-pixel
// scroll position for the two-layer background.
module scroll_scheduler
  import scroll_pkg::*;
#(
  parameter int SCREEN_W_P        = SCREEN_W,
  parameter int SCALE_P           = SCALE,
  parameter int MIN_SPEED_P       = MIN_SPEED,
  parameter int SPEED_PER_SCORE_P = SPEED_PER_SCORE,
  parameter int MAX_SPEED_P       = MAX_SPEED,
  parameter int RAMP_STEP_P       = RAMP_STEP
) (
  input logic animationClOCK,
  input logic resetN,
  scroll_scheduler_if.slave bus
);

  localparam logic [POS_W-1:0] POS_INIT =
    POS_W'(SCREEN_W_P * SCALE_P);
  localparam logic [SPD_W-1:0] RAMP =
    SPD_W'(RAMP_STEP_P);
  localparam logic [SPD_W-1:0] SMAX =
    SPD_W'(MAX_SPEED_P);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [SPD_W-1:0] tgt_raw, target;
  logic             wrap_q, wrap_d;
  logic             moving, wrap, restart;
  logic [PIX_W-1:0] x, skip;

  assign tgt_raw = SPD_W'(MIN_SPEED_P) +
    SPD_W'(SPEED_PER_SCORE_P) * SPD_W'(bus.score);
  assign target = (tgt_raw > SMAX) ? SMAX : tgt_raw;

  assign moving = bus.frameTick &&
    (state_q == S_RUN || state_q == S_OVER);
  assign wrap = pos_q < POS_W'(speed_q);
  assign restart = (state_q == S_OVER) &&
    bus.start && !bus.gameOver;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.gameOver) state_d = S_OVER;
        else if (!bus.pause && bus.start)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.gameOver) state_d = S_OVER;
        else if (bus.pause) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (bus.gameOver) state_d = S_OVER;
        else if (!bus.pause) state_d = S_RUN;
      end
      default: begin
        if (restart) state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    if (bus.frameTick && state_q == S_RUN) begin
      if (target >= speed_q)
        speed_d = (target - speed_q <= RAMP) ?
                  target : speed_q + RAMP;
      else
        speed_d = (speed_q - target <= RAMP) ?
                  target : speed_q - RAMP;
    end else if (bus.frameTick && state_q == S_OVER) begin
      speed_d = (speed_q > RAMP) ? speed_q - RAMP : '0;
    end
    if (restart) speed_d = '0;
  end

  // wrap keeps the sub-pixel remainder instead of snapping
  always_comb begin
    pos_d = pos_q;
    if (moving) begin
      if (wrap) pos_d = pos_q + POS_INIT - POS_W'(speed_q);
      else      pos_d = pos_q - POS_W'(speed_q);
    end
    if (restart) pos_d = POS_INIT;
  end

  assign wrap_d = moving && wrap;

  always_ff @(posedge animationClOCK or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      pos_q   <= POS_INIT;
      speed_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      speed_q <= speed_d;
      wrap_q  <= wrap_d;
    end
  end

  scroll_pixel_div #(
    .SCREEN_W_P (SCREEN_W_P),
    .SCALE_P    (SCALE_P)
  ) u_div (
    .clk   (animationClOCK),
    .rst_n (resetN),
    .pos   (pos_q),
    .x     (x),
    .skip  (skip)
  );

  assign bus.BACK1X     = x;
  assign bus.BACK2SKIPX = skip;
  assign bus.BACK1Y     = '0;
  assign bus.BACK2X     = '0;
  assign bus.BACK2Y     = '0;
  assign bus.BACK1SKIPX = '0;
  assign bus.wrapPulse  = wrap_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// tb_scroll_scheduler: directed plus random stimulus checked
// against a frame-level behavioural model of the scroller.
module tb_scroll_scheduler;

  logic clk;
  logic resetN;

  scroll_scheduler_if bus ();

  scroll_scheduler dut (
    .animationClOCK (clk),
    .resetN         (resetN),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: 0 idle, 1 run, 2 paused, 3 over
  int m_state, m_pos, m_spd, m_x, m_skip;
  bit m_wrap;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 64000; m_spd = 0;
    m_x = 640; m_skip = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit t, input bit st,
                            input bit pa, input bit go,
                            input int sc);
    int os, op, ov, tgt, d;
    os = m_state; op = m_pos; ov = m_spd;
    m_x = (op / 100 > 640) ? 640 : op / 100;
    m_skip = 640 - m_x;
    m_wrap = t && (os == 1 || os == 3) && op < ov;
    if (t && (os == 1 || os == 3))
      m_pos = (op >= ov) ? op - ov : op + 64000 - ov;
    if (t && os == 1) begin
      tgt = 100 + 30 * sc;
      if (tgt > 3000) tgt = 3000;
      d = tgt - ov;
      if (d > 50) m_spd = ov + 50;
      else if (d < -50) m_spd = ov - 50;
      else m_spd = tgt;
    end else if (t && os == 3) begin
      m_spd = (ov > 50) ? ov - 50 : 0;
    end
    case (os)
      0: if (go) m_state = 3;
         else if (!pa && st) m_state = 1;
      1: if (go) m_state = 3;
         else if (pa) m_state = 2;
      2: if (go) m_state = 3;
         else if (!pa) m_state = 1;
      default:
         if (st && !go) begin
           m_state = 1; m_pos = 64000; m_spd = 0;
         end
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(bus.state), m_state);
    chk("back1x", 32'(bus.BACK1X), m_x);
    chk("back2skipx", 32'(bus.BACK2SKIPX), m_skip);
    chk("wrap", 32'(bus.wrapPulse), 32'(m_wrap));
    chk("pos", 32'(dut.pos_q), m_pos);
    chk("speed", 32'(dut.speed_q), m_spd);
    chk("consts", 32'({bus.BACK1Y, bus.BACK2X,
        bus.BACK2Y, bus.BACK1SKIPX}), 0);
  endtask

  task automatic step(input bit t, input bit st,
                      input bit pa, input bit go,
                      input int sc);
    bus.frameTick = t;
    bus.start     = st;
    bus.pause     = pa;
    bus.gameOver  = go;
    bus.score     = 10'(sc);
    @(posedge clk);
    #1;
    model_edge(t, st, pa, go, sc);
    check_all();
  endtask

  initial begin
    int p0, sc;
    bit seen, pa;
    bus.frameTick = 0; bus.start = 0;
    bus.pause = 0; bus.gameOver = 0;
    bus.score = '0;
    resetN = 1'b0;
    model_reset();
    #12;
    check_all();
    resetN = 1'b1;

    step(0, 1, 0, 0, 0);
    chk("run_after_start", 32'(bus.state), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    chk("tick3_speed", 32'(dut.speed_q), 100);
    chk("tick3_pos", 32'(dut.pos_q), 63850);
    chk("tick3_x", 32'(bus.BACK1X), 638);
    chk("tick3_skip", 32'(bus.BACK2SKIPX), 2);

    seen = 0;
    for (int i = 0; i < 800 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      seen = m_wrap;
      chk("wrap_pulse_now", 32'(bus.wrapPulse),
          32'(m_wrap));
      step(0, 0, 0, 0, 0);
    end
    chk("wrap_seen", 32'(seen), 1);
    chk("wrap_pulse_gone", 32'(bus.wrapPulse), 0);
    chk("wrap_pos", 32'(dut.pos_q), 63950);
    chk("wrap_x", 32'(bus.BACK1X), 639);

    step(0, 0, 1, 0, 0);
    p0 = m_pos;
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    chk("pause_state", 32'(bus.state), 2);
    chk("pause_pos", 32'(dut.pos_q), p0);
    chk("pause_speed", 32'(dut.speed_q), 100);
    step(0, 0, 0, 0, 0);
    chk("unpause_state", 32'(bus.state), 1);
    step(1, 0, 0, 0, 0);
    chk("resume_pos", 32'(dut.pos_q), p0 - 100);

    step(0, 0, 0, 1, 0);
    chk("over_state", 32'(bus.state), 3);
    p0 = m_pos;
    step(1, 0, 0, 0, 0);
    chk("over_spd1", 32'(dut.speed_q), 50);
    chk("over_pos1", 32'(dut.pos_q), p0 - 100);
    step(1, 0, 0, 0, 0);
    chk("over_spd2", 32'(dut.speed_q), 0);
    chk("over_pos2", 32'(dut.pos_q), p0 - 150);
    step(1, 0, 0, 0, 0);
    chk("over_pos3", 32'(dut.pos_q), p0 - 150);
    step(0, 1, 0, 0, 0);
    chk("restart_state", 32'(bus.state), 1);
    chk("restart_pos", 32'(dut.pos_q), 64000);

    for (int i = 1; i <= 70; i++) begin
      step(1, 0, 0, 0, 1023);
      n_chk++;
      assert (dut.speed_q <= 16'd3000) else begin
        n_fail++;
        $error("FAIL ramp_clamp: got %0d expected <=3000",
               dut.speed_q);
      end
      if (i == 59)
        chk("ramp_59", 32'(dut.speed_q), 2950);
      if (i == 60)
        chk("ramp_60", 32'(dut.speed_q), 3000);
    end

    pa = 0;
    sc = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) pa = ~pa;
      if ($urandom_range(0, 19) == 0)
        sc = $urandom_range(0, 1023);
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 14) == 0, pa,
           $urandom_range(0, 59) == 0, sc);
    end

    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 200);
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    model_reset();
    chk("areset_x", 32'(bus.BACK1X), 640);
    chk("areset_skip", 32'(bus.BACK2SKIPX), 0);
    chk("areset_state", 32'(bus.state), 0);
    chk("areset_wrap", 32'(bus.wrapPulse), 0);
    chk("areset_pos", 32'(dut.pos_q), 64000);
    #10;
    resetN = 1'b1;
    step(0, 1, 1, 1, 0);
    chk("prio_over", 32'(bus.state), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
